mac_dot_sequencer: RTL and testbench

Drives the operand side of the MAC interface (En, Clr, Ain, Bin) and collects the accumulated Cout. It pops paired operands from an A FIFO and a B FIFO, clears the MAC, and feeds exactly VEC_LEN operand pairs. It then captures the final dot product and presents it with a one-cycle valid pulse. It sits between the operand FIFOs and the MAC, acting as the initiator that the MAC responds to.

---
 rtl/mac_dot_if.sv | 35 +++
 rtl/mac_dot_sequencer.sv | 107 ++++++++++
 tb/tb_mac_dot_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_if.sv
// Operand-FIFO / MAC bundle between the dot-product sequencer (master) and
// its environment (slave).
interface mac_dot_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
);
    logic              start;
    logic              abort;
    logic              a_empty;
    logic [DATA_W-1:0] a_rdata;
    logic              a_rden;
    logic              b_empty;
    logic [DATA_W-1:0] b_rdata;
    logic              b_rden;
    logic              mac_en;
    logic              mac_clr;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_cout;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              busy;

    modport master (
        input  start, abort, a_empty, a_rdata, b_empty, b_rdata, mac_cout,
        output a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b,
               result, result_valid, busy
    );

    modport slave (
        output start, abort, a_empty, a_rdata, b_empty, b_rdata, mac_cout,
        input  a_rden, b_rden, mac_en, mac_clr, mac_a, mac_b,
               result, result_valid, busy
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Pops paired operands from the A/B FIFOs, feeds VEC_LEN of them into a
// clear-then-accumulate MAC and captures the final dot product.
module mac_dot_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int VEC_LEN = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    mac_dot_if.master bus
);
    localparam int              CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FEED, DRAIN, DONE, ABORT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  issued;
    logic              rden;
    logic              clr;
    logic              valid;
    logic              busy;
    logic              en_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [ACC_W-1:0]  result;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rden      = 1'b0;
        clr       = 1'b0;
        valid     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (bus.start) state_nxt = CLEAR;
            CLEAR: begin
                clr       = 1'b1;
                state_nxt = FEED;
            end
            FEED: begin
                rden = !bus.a_empty && !bus.b_empty && (issued < LAST);
                // The pair popped last cycle is on mac_en now, so the MAC
                // holds the full sum once DRAIN starts.
                if (issued == LAST) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                valid     = 1'b1;
                state_nxt = IDLE;
            end
            ABORT: begin
                clr       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a pop in this very cycle.
        if (bus.abort && state != IDLE && state != ABORT) begin
            rden      = 1'b0;
            state_nxt = ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)              issued <= '0;
        else if (state == CLEAR) issued <= '0;
        else if (rden)           issued <= issued + 1'b1;
    end

    // Stage p1: FIFO read data is sampled on the edge that ends the pop cycle,
    // so operands and mac_en line up and hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_p1 <= 1'b0;
            a_p1  <= '0;
            b_p1  <= '0;
        end else begin
            en_p1 <= rden;
            if (rden) begin
                a_p1 <= bus.a_rdata;
                b_p1 <= bus.b_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)              result <= '0;
        else if (state == DRAIN) result <= bus.mac_cout;
    end

    assign bus.a_rden       = rden;
    assign bus.b_rden       = rden;
    assign bus.mac_en       = en_p1;
    assign bus.mac_clr      = clr;
    assign bus.mac_a        = a_p1;
    assign bus.mac_b        = b_p1;
    assign bus.result       = result;
    assign bus.result_valid = valid;
    assign bus.busy         = busy;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: per-cycle vector tables plus
// hand-written abort, restart and reset sequences, with FIFO and MAC models.
module tb_mac_dot_sequencer;
    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic stall_b = 1'b0;
    int   n_vec   = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mac_dot_if #(.DATA_W(8), .ACC_W(24)) if4 ();
    mac_dot_if #(.DATA_W(8), .ACC_W(24)) if8 ();

    mac_dot_sequencer #(.DATA_W(8), .ACC_W(24), .VEC_LEN(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(if4));
    mac_dot_sequencer #(.DATA_W(8), .ACC_W(24), .VEC_LEN(8)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(if8));

    // FIFO models: show-ahead data at the head, pop on the edge where rden=1
    logic [7:0]  mem4a [256];
    logic [7:0]  mem4b [256];
    logic [7:0]  mem8a [256];
    logic [7:0]  mem8b [256];
    logic [7:0]  hd4a = '0, hd4b = '0, tl4a = '0, tl4b = '0;
    logic [7:0]  hd8a = '0, hd8b = '0, tl8a = '0, tl8b = '0;
    logic [23:0] acc4 = '0, acc8 = '0;
    int pops4 = 0, ens4 = 0, rvs4 = 0, split4 = 0;
    int ens8 = 0, split8 = 0;

    assign if4.a_empty  = (hd4a == tl4a);
    assign if4.b_empty  = (hd4b == tl4b) || stall_b;
    assign if4.a_rdata  = mem4a[hd4a];
    assign if4.b_rdata  = mem4b[hd4b];
    assign if4.mac_cout = acc4;
    assign if8.a_empty  = (hd8a == tl8a);
    assign if8.b_empty  = (hd8b == tl8b);
    assign if8.a_rdata  = mem8a[hd8a];
    assign if8.b_rdata  = mem8b[hd8b];
    assign if8.mac_cout = acc8;

    always @(posedge clk) begin
        if (if4.a_rden && hd4a != tl4a) hd4a <= hd4a + 8'd1;
        if (if4.b_rden && hd4b != tl4b) hd4b <= hd4b + 8'd1;
        if (if8.a_rden && hd8a != tl8a) hd8a <= hd8a + 8'd1;
        if (if8.b_rden && hd8b != tl8b) hd8b <= hd8b + 8'd1;
        if (if4.a_rden) pops4 <= pops4 + 1;
        if (if4.mac_en) ens4 <= ens4 + 1;
        if (if4.result_valid) rvs4 <= rvs4 + 1;
        if (if4.a_rden != if4.b_rden) split4 <= split4 + 1;
        if (if8.mac_en) ens8 <= ens8 + 1;
        if (if8.a_rden != if8.b_rden) split8 <= split8 + 1;
        // MAC model: registered accumulator, clear wins over enable
        if (!rst_n || if4.mac_clr) acc4 <= '0;
        else if (if4.mac_en) acc4 <= acc4 + {16'd0, if4.mac_a} * {16'd0, if4.mac_b};
        if (!rst_n || if8.mac_clr) acc8 <= '0;
        else if (if8.mac_en) acc8 <= acc8 + {16'd0, if8.mac_a} * {16'd0, if8.mac_b};
    end

    // ctl = {start, stall_b, mac_clr, rden, mac_en, busy, result_valid}
    typedef struct packed {
        logic [6:0]  ctl;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [23:0] res;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic load4(input logic [31:0] av, input logic [31:0] bv);
        tl4a = hd4a;
        tl4b = hd4b;
        for (int i = 3; i >= 0; i--) begin
            mem4a[tl4a] = av[8*i +: 8];
            mem4b[tl4b] = bv[8*i +: 8];
            tl4a = tl4a + 8'd1;
            tl4b = tl4b + 8'd1;
        end
    endtask

    task automatic load8(input logic [7:0] v);
        tl8a = hd8a;
        tl8b = hd8b;
        for (int i = 0; i < 8; i++) begin
            mem8a[tl8a] = v;
            mem8b[tl8b] = v;
            tl8a = tl8a + 8'd1;
            tl8b = tl8b + 8'd1;
        end
    endtask

    // Pulses start on u4 and waits (bounded) for result_valid.
    task automatic start_wait4(input string nm, input int maxc);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if4.start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            if (c == 1) if4.start = 1'b0;
            #1;
            if (if4.result_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk1({nm, " result_valid seen"}, got, 1'b1);
    endtask

    task automatic run8(input string nm, input logic [23:0] exp_res);
        bit got;
        int e0, clr_c, en_c;
        got = 1'b0;
        e0 = ens8;
        clr_c = -1;
        en_c = -1;
        @(negedge clk);
        if8.start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) if8.start = 1'b0;
            #1;
            if (if8.mac_clr && clr_c < 0) clr_c = c;
            if (if8.mac_en && en_c < 0) en_c = c;
            if (if8.result_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk1({nm, " result_valid seen"}, got, 1'b1);
        chkv({nm, " result"}, 32'(if8.result), 32'(exp_res));
        chk1({nm, " clr before first mac_en"}, (clr_c >= 0) && (en_c > clr_c), 1'b1);
        @(negedge clk);
        chkv({nm, " mac_en pulses"}, ens8 - e0, 8);
        chk1({nm, " idle after"}, if8.busy, 1'b0);
    endtask

    initial begin
        int p0, e0, r0;
        tbl[0]  = '{7'b1000000, 8'd0, 8'd0, 24'd0};
        tbl[1]  = '{7'b0010010, 8'd0, 8'd0, 24'd0};
        tbl[2]  = '{7'b0001010, 8'd0, 8'd0, 24'd0};
        tbl[3]  = '{7'b0001110, 8'd1, 8'd5, 24'd0};
        tbl[4]  = '{7'b0001110, 8'd2, 8'd6, 24'd0};
        tbl[5]  = '{7'b0001110, 8'd3, 8'd7, 24'd0};
        tbl[6]  = '{7'b0000110, 8'd4, 8'd8, 24'd0};
        tbl[7]  = '{7'b0000010, 8'd4, 8'd8, 24'd0};
        tbl[8]  = '{7'b0000011, 8'd4, 8'd8, 24'd70};
        tbl[9]  = '{7'b0000000, 8'd4, 8'd8, 24'd70};
        tbl[10] = '{7'b1000000, 8'd4, 8'd8, 24'd70};
        tbl[11] = '{7'b0010010, 8'd4, 8'd8, 24'd70};
        tbl[12] = '{7'b0001010, 8'd4, 8'd8, 24'd70};
        tbl[13] = '{7'b0001110, 8'd1, 8'd5, 24'd70};
        tbl[14] = '{7'b0100110, 8'd2, 8'd6, 24'd70};
        tbl[15] = '{7'b0100010, 8'd2, 8'd6, 24'd70};
        tbl[16] = '{7'b0100010, 8'd2, 8'd6, 24'd70};
        tbl[17] = '{7'b0001010, 8'd2, 8'd6, 24'd70};
        tbl[18] = '{7'b0001110, 8'd3, 8'd7, 24'd70};
        tbl[19] = '{7'b0000110, 8'd4, 8'd8, 24'd70};
        tbl[20] = '{7'b0000010, 8'd4, 8'd8, 24'd70};
        tbl[21] = '{7'b0000011, 8'd4, 8'd8, 24'd70};
        tbl[22] = '{7'b0000000, 8'd4, 8'd8, 24'd70};

        if4.start = 1'b0;
        if4.abort = 1'b0;
        if8.start = 1'b0;
        if8.abort = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("reset mac_clr", if4.mac_clr, 1'b0);
        chk1("reset rden", if4.a_rden, 1'b0);
        chk1("reset mac_en", if4.mac_en, 1'b0);
        chk1("reset busy", if4.busy, 1'b0);
        chk1("reset result_valid", if4.result_valid, 1'b0);
        chkv("reset mac_a", 32'(if4.mac_a), 0);
        chkv("reset mac_b", 32'(if4.mac_b), 0);
        chkv("reset result", 32'(if4.result), 0);

        // Cycle-by-cycle tables: no-stall run, then run with a 3-cycle B stall
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (tbl[i].ctl[6]) load4({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
            if4.start = tbl[i].ctl[6];
            stall_b   = tbl[i].ctl[5];
            #1;
            chk1($sformatf("v%0d mac_clr", i), if4.mac_clr, tbl[i].ctl[4]);
            chk1($sformatf("v%0d a_rden", i), if4.a_rden, tbl[i].ctl[3]);
            chk1($sformatf("v%0d b_rden", i), if4.b_rden, tbl[i].ctl[3]);
            chk1($sformatf("v%0d mac_en", i), if4.mac_en, tbl[i].ctl[2]);
            chk1($sformatf("v%0d busy", i), if4.busy, tbl[i].ctl[1]);
            chk1($sformatf("v%0d result_valid", i), if4.result_valid, tbl[i].ctl[0]);
            chkv($sformatf("v%0d mac_a", i), 32'(if4.mac_a), 32'(tbl[i].ea));
            chkv($sformatf("v%0d mac_b", i), 32'(if4.mac_b), 32'(tbl[i].eb));
            chkv($sformatf("v%0d result", i), 32'(if4.result), 32'(tbl[i].res));
        end
        @(negedge clk);
        if4.start = 1'b0;
        stall_b   = 1'b0;

        // Full-scale operands, then a fresh run that must not carry over
        load8(8'd255);
        run8("u8 all-255", 24'h07F008);
        load8(8'd1);
        run8("u8 all-1", 24'd8);

        // start re-pulsed during FEED is ignored
        load4({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
        p0 = pops4;
        e0 = ens4;
        r0 = rvs4;
        @(negedge clk);
        if4.start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if4.start = (c == 3);
        end
        chkv("restart result_valid count", rvs4 - r0, 1);
        chkv("restart pops", pops4 - p0, 4);
        chkv("restart mac_en pulses", ens4 - e0, 4);
        chkv("restart result", 32'(if4.result), 70);
        chk1("restart idle after", if4.busy, 1'b0);

        // abort in IDLE does nothing
        @(negedge clk);
        if4.abort = 1'b1;
        @(negedge clk);
        if4.abort = 1'b0;
        #1;
        chk1("idle abort busy", if4.busy, 1'b0);
        chk1("idle abort mac_clr", if4.mac_clr, 1'b0);

        // abort after two pops
        load4({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
        p0 = pops4;
        r0 = rvs4;
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        if4.abort = 1'b1;
        #1;
        chk1("abort cycle no pop", if4.a_rden, 1'b0);
        @(negedge clk);
        if4.abort = 1'b0;
        #1;
        chk1("abort+1 mac_clr", if4.mac_clr, 1'b1);
        chk1("abort+1 rden", if4.a_rden, 1'b0);
        chk1("abort+1 mac_en", if4.mac_en, 1'b0);
        chk1("abort+1 busy", if4.busy, 1'b1);
        @(negedge clk);
        #1;
        chk1("abort+2 busy", if4.busy, 1'b0);
        chk1("abort+2 mac_clr", if4.mac_clr, 1'b0);
        repeat (5) @(negedge clk);
        chkv("abort pops", pops4 - p0, 2);
        chkv("abort result_valid count", rvs4 - r0, 0);
        chkv("abort result kept", 32'(if4.result), 70);
        load4({8'd2, 8'd2, 8'd2, 8'd2}, {8'd3, 8'd3, 8'd3, 8'd3});
        start_wait4("post-abort", 30);
        chkv("post-abort result", 32'(if4.result), 24);

        // reset for one cycle mid-FEED
        load4({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk1("mid-reset rden", if4.a_rden, 1'b0);
        chk1("mid-reset mac_en", if4.mac_en, 1'b0);
        chk1("mid-reset mac_clr", if4.mac_clr, 1'b0);
        chk1("mid-reset busy", if4.busy, 1'b0);
        chk1("mid-reset result_valid", if4.result_valid, 1'b0);
        chkv("mid-reset mac_a", 32'(if4.mac_a), 0);
        chkv("mid-reset result", 32'(if4.result), 0);
        @(negedge clk);
        #1;
        chk1("post-reset no rden", if4.a_rden, 1'b0);
        chk1("post-reset busy", if4.busy, 1'b0);
        load4({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8});
        e0 = ens4;
        start_wait4("post-reset", 30);
        chkv("post-reset result", 32'(if4.result), 70);
        chkv("post-reset mac_en pulses", ens4 - e0, 4);

        chkv("u4 rden pairing", split4, 0);
        chkv("u8 rden pairing", split8, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
